// File: rtl/int_to_fp_conv.sv
// int_to_fp_conv: converts a 32-bit integer (signed or unsigned) to an
// IEEE-754 single-precision word. Each operand takes four single-cycle
// states: IDLE, NORM, ROUND and DONE. Only one conversion is in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   int_in, signed_mode operand, and 1 = two's complement / 0 = unsigned
//   out_valid/out_ready result handshake; out_valid is high only in DONE
//   fp_out, inexact     packed result, and a flag that nonzero bits were
//                       discarded; both hold until the next DONE
// ROUND_MODE: 0 = round-to-nearest-even, 1 = round-toward-zero.
module int_to_fp_conv #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        signed_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_out,
  output logic        inexact
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic        sign_q;
  logic [31:0] mag_q;
  logic        zero_q;
  logic [7:0]  exp_q;
  logic [22:0] man_q;
  logic        g_q, r_q, s_q;
  logic [31:0] fp_q;
  logic        inexact_q;

  // Both handshake outputs come straight from the state register. No input
  // reaches them combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign fp_out    = fp_q;
  assign inexact   = inexact_q;

  // Leading-zero count of the magnitude. The highest set bit wins.
  logic [4:0]  lz;
  logic [31:0] norm;
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++)
      if (mag_q[i]) lz = 5'(31 - i);
  end
  assign norm = mag_q << lz;

  // Rounding increment. A carry out of the 23-bit mantissa leaves man = 0,
  // so only the exponent has to be bumped. The largest exponent is 159,
  // so the result cannot overflow.
  logic        inc;
  logic [23:0] man_sum;
  logic [7:0]  exp_rnd;
  assign inc     = (ROUND_MODE == 0) && g_q && (r_q || s_q || man_q[0]);
  assign man_sum = {1'b0, man_q} + {23'd0, inc};
  assign exp_rnd = man_sum[23] ? exp_q + 8'd1 : exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      zero_q    <= 1'b0;
      exp_q     <= 8'd0;
      man_q     <= 23'd0;
      g_q       <= 1'b0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      fp_q      <= 32'd0;
      inexact_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= signed_mode & int_in[31];
          // 0x80000000 in signed mode negates to itself. Read as unsigned,
          // that is the correct magnitude 2^31.
          mag_q  <= (signed_mode & int_in[31]) ? (~int_in + 32'd1) : int_in;
          state  <= NORM;
        end
        NORM: begin
          zero_q <= (mag_q == 32'd0);
          exp_q  <= 8'd158 - {3'd0, lz};   // 127 + (31 - lz)
          man_q  <= norm[30:8];
          g_q    <= norm[7];
          r_q    <= norm[6];
          s_q    <= |norm[5:0];
          state  <= ROUND;
        end
        ROUND: begin
          if (zero_q) begin
            // Only a zero magnitude gets here, so the result is +0.
            fp_q      <= 32'd0;
            inexact_q <= 1'b0;
          end else begin
            fp_q      <= {sign_q, exp_rnd, man_sum[22:0]};
            inexact_q <= g_q | r_q | s_q;
          end
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_conv.sv
// Directed bench for int_to_fp_conv. Two instances share all inputs: one
// rounds to nearest even and the other rounds toward zero. Every expected
// value in this file was worked out by hand.
module tb_int_to_fp_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] int_in = 32'd0;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, inexact0;
  logic        in_ready1, out_valid1, inexact1;
  logic [31:0] fp_out0, fp_out1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  int_to_fp_conv #(.ROUND_MODE(0)) dut_rne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .int_in(int_in), .signed_mode(signed_mode), .out_valid(out_valid0),
    .out_ready(out_ready), .fp_out(fp_out0), .inexact(inexact0)
  );

  int_to_fp_conv #(.ROUND_MODE(1)) dut_rtz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .int_in(int_in), .signed_mode(signed_mode), .out_valid(out_valid1),
    .out_ready(out_ready), .fp_out(fp_out1), .inexact(inexact1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one operand and checks the cycle-accurate latency. The operand
  // is accepted on the first edge, and out_valid must be high once two more
  // edges have passed (cycle T+3, counting the accept cycle as T). The task
  // then does the handoff and checks that the results hold afterwards.
  task automatic conv(input string tag, input logic [31:0] v, input logic sm,
                      input logic [31:0] e_rne, input logic [31:0] e_rtz,
                      input logic ix);
    @(negedge clk);
    int_in = v; signed_mode = sm; in_valid = 1'b1;
    chk({tag, ".in_ready"}, {31'd0, in_ready0 & in_ready1}, 32'd1);
    @(negedge clk);                       // after accept edge: NORM
    in_valid = 1'b0;
    chk({tag, ".ov_t1"}, {31'd0, out_valid0 | out_valid1}, 32'd0);
    @(negedge clk);                       // ROUND
    chk({tag, ".ov_t2"}, {31'd0, out_valid0 | out_valid1}, 32'd0);
    @(negedge clk);                       // DONE
    chk({tag, ".ov_t3"}, {30'd0, out_valid1, out_valid0}, 32'd3);
    chk({tag, ".rne"}, fp_out0, e_rne);
    chk({tag, ".rtz"}, fp_out1, e_rtz);
    chk({tag, ".inexact"}, {30'd0, inexact1, inexact0}, {30'd0, ix, ix});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".post_ov"}, {30'd0, out_valid1, out_valid0}, 32'd0);
    chk({tag, ".hold"}, fp_out0, e_rne);
  endtask

  initial begin
    // Reset state, sampled while rst_n is still low.
    #12;
    chk("rst.in_ready", {31'd0, in_ready0}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst.fp_out", fp_out0, 32'd0);
    chk("rst.inexact", {31'd0, inexact0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv("s_one",    32'h0000_0001, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    conv("s_neg1",   32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 32'hBF80_0000, 1'b0);
    conv("s_zero",   32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    conv("s_min",    32'h8000_0000, 1'b1, 32'hCF00_0000, 32'hCF00_0000, 1'b0);
    conv("u_msb",    32'h8000_0000, 1'b0, 32'h4F00_0000, 32'h4F00_0000, 1'b0);
    conv("u_max",    32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 32'h4F7F_FFFF, 1'b1);
    conv("tie_even", 32'h0100_0001, 1'b0, 32'h4B80_0000, 32'h4B80_0000, 1'b1);
    conv("tie_odd",  32'h0100_0003, 1'b0, 32'h4B80_0002, 32'h4B80_0001, 1'b1);
    conv("s_m100",   32'hFFFF_FF9C, 1'b1, 32'hC2C8_0000, 32'hC2C8_0000, 1'b0);

    // Backpressure: hold DONE for 5 cycles while a new operand waits.
    @(negedge clk);
    int_in = 32'd1; signed_mode = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    int_in = 32'd5;                       // stays valid the whole time
    @(negedge clk);
    @(negedge clk);                       // DONE
    for (int i = 0; i < 5; i++) begin
      chk("bp.fp_stable", fp_out0, 32'h3F80_0000);
      chk("bp.in_ready", {31'd0, in_ready0}, 32'd0);
      chk("bp.out_valid", {31'd0, out_valid0}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);                       // IDLE again
    out_ready = 1'b0;
    chk("bp.idle_ready", {31'd0, in_ready0}, 32'd1);
    chk("bp.idle_ov", {31'd0, out_valid0}, 32'd0);
    @(negedge clk);                       // the waiting operand 5 is accepted
    in_valid = 1'b0;
    chk("bp.accepted", {31'd0, in_ready0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bp.ov", {31'd0, out_valid0}, 32'd1);
    chk("bp.new_fp", fp_out0, 32'h40A0_0000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a ROUND cycle.
    @(negedge clk);
    int_in = 32'd7; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);                       // NORM
    in_valid = 1'b0;
    @(negedge clk);                       // ROUND, mid-cycle
    #1 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, out_valid0}, 32'd0);
    chk("arst.fp_out", fp_out0, 32'd0);
    chk("arst.in_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    chk("arst.no_out", {31'd0, out_valid0}, 32'd0);
    rst_n = 1'b1;
    conv("after_rst", 32'd5, 1'b0, 32'h40A0_0000, 32'h40A0_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
